// File: rtl/dogx_output_serializer.sv
// Serializes 11-bit DOGX converter samples into framed MSB-first SCLK/SDO/FS output.
// A one-deep holding register sits between the sample strobe and the shifter; lost samples flag overrun.
module dogx_output_serializer #(
  parameter int DATA_W     = 11,
  parameter int FRAME_BITS = 16,
  parameter int CLK_DIV    = 1
)(
  input  logic              CLK_24M,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic              overrun_clr,
  output logic              sclk_out,
  output logic              sdo,
  output logic              fs,
  output logic              busy,
  output logic              overrun
);
  localparam int PW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW  = (FRAME_BITS > 2) ? $clog2(FRAME_BITS) : 1;
  localparam int PAD = FRAME_BITS - DATA_W;

  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nxt;

  logic [PW-1:0]         presc;
  logic [BW-1:0]         bitcnt;
  logic [FRAME_BITS-1:0] shreg;
  logic [DATA_W-1:0]     hold;
  logic                  hold_full;
  logic                  tick, fall, last_bit;
  logic                  load, shift, stop;

  assign tick     = en && (presc == PW'(CLK_DIV - 1));
  assign fall     = tick && sclk_out;
  assign last_bit = (bitcnt == BW'(FRAME_BITS - 1));
  // sdo is the shifter MSB; shreg is cleared whenever the link idles
  assign sdo      = shreg[FRAME_BITS-1];

  always_ff @(posedge CLK_24M) begin
    if (!reset || !en) state <= IDLE;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (fall && hold_full)             state_nxt = SHIFT;
      SHIFT: if (fall && last_bit && !hold_full) state_nxt = IDLE;
      default:                                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load  = 1'b0;
    shift = 1'b0;
    stop  = 1'b0;
    if (fall) begin
      case (state)
        IDLE:  load = hold_full;
        SHIFT: begin
          if (last_bit) begin
            load = hold_full;
            stop = !hold_full;
          end else begin
            shift = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK_24M) begin
    if (!reset) begin
      presc     <= '0;
      sclk_out  <= 1'b0;
      hold      <= '0;
      hold_full <= 1'b0;
      overrun   <= 1'b0;
      shreg     <= '0;
      fs        <= 1'b0;
      busy      <= 1'b0;
      bitcnt    <= '0;
    end else begin
      if (!en) begin
        presc    <= '0;
        sclk_out <= 1'b0;
      end else if (tick) begin
        presc    <= '0;
        sclk_out <= ~sclk_out;
      end else begin
        presc    <= presc + 1'b1;
      end

      // A strobe landing on the consume cycle refills the hold without loss
      if (sample_valid) begin
        hold      <= sample_in;
        hold_full <= 1'b1;
      end else if (load || !en) begin
        hold_full <= 1'b0;
      end

      if (sample_valid && hold_full && !load) overrun <= 1'b1;
      else if (overrun_clr)                   overrun <= 1'b0;

      if (!en || stop) begin
        shreg  <= '0;
        fs     <= 1'b0;
        busy   <= 1'b0;
        bitcnt <= '0;
      end else if (load) begin
        shreg  <= FRAME_BITS'(hold) << PAD;
        fs     <= 1'b1;
        busy   <= 1'b1;
        bitcnt <= '0;
      end else if (shift) begin
        shreg  <= shreg << 1;
        fs     <= 1'b0;
        bitcnt <= bitcnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dogx_output_serializer.sv
// Bench for dogx_output_serializer: CLK_DIV=1 and CLK_DIV=3 instances share stimulus and are
// compared every cycle against an arithmetic frame/hold model, plus directed scenario checks.
module tb_dogx_output_serializer;
  localparam int DW = 11;
  localparam int FB = 16;

  logic          clk = 1'b0;
  logic          rst_n, en, sv, clr;
  logic [DW-1:0] sin;
  logic [1:0]    sclk, sdo, fs, busy, ovr;

  dogx_output_serializer #(.DATA_W(DW), .FRAME_BITS(FB), .CLK_DIV(1)) u_dut1 (
    .CLK_24M(clk), .reset(rst_n), .en(en), .sample_in(sin), .sample_valid(sv),
    .overrun_clr(clr), .sclk_out(sclk[0]), .sdo(sdo[0]), .fs(fs[0]), .busy(busy[0]),
    .overrun(ovr[0]));

  dogx_output_serializer #(.DATA_W(DW), .FRAME_BITS(FB), .CLK_DIV(3)) u_dut3 (
    .CLK_24M(clk), .reset(rst_n), .en(en), .sample_in(sin), .sample_valid(sv),
    .overrun_clr(clr), .sclk_out(sclk[1]), .sdo(sdo[1]), .fs(fs[1]), .busy(busy[1]),
    .overrun(ovr[1]));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Model: cycles since enable give sclk phase; pos is the bit index in the frame (-1 idle)
  int            m_cnt [2];
  int            m_pos [2];
  bit            m_hf  [2];
  bit            m_ovr [2];
  logic [DW-1:0] m_hold[2];
  logic [FB-1:0] m_word[2];

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int d;
      bit fall, consume, set;
      d = (i == 0) ? 1 : 3;
      fall = 0;
      consume = 0;
      if (!rst_n) begin
        m_cnt[i] = 0; m_pos[i] = -1; m_hf[i] = 0; m_ovr[i] = 0;
      end else begin
        if (en) begin
          m_cnt[i]++;
          fall = (m_cnt[i] % d == 0) && ((m_cnt[i] / d) % 2 == 0);
        end else begin
          m_cnt[i] = 0;
        end
        if (!en) m_pos[i] = -1;
        else if (fall) begin
          if (m_pos[i] >= 0 && m_pos[i] < FB - 1) m_pos[i]++;
          else if (m_hf[i]) begin
            m_word[i] = FB'(m_hold[i]) << (FB - DW);
            m_pos[i] = 0;
            consume = 1;
          end else m_pos[i] = -1;
        end
        set = sv && m_hf[i] && !consume;
        if (sv) begin m_hold[i] = sin; m_hf[i] = 1; end
        else if (consume || !en) m_hf[i] = 0;
        if (set) m_ovr[i] = 1;
        else if (clr) m_ovr[i] = 0;
      end
    end
  endtask

  function automatic logic [7:0] exp_vec(input int i);
    int d;
    logic s, b;
    d = (i == 0) ? 1 : 3;
    s = ((m_cnt[i] / d) % 2) == 1;
    b = (m_pos[i] >= 0) ? m_word[i][FB-1-m_pos[i]] : 1'b0;
    return {3'b0, s, b, m_pos[i] == 0, m_pos[i] >= 0, m_ovr[i]};
  endfunction

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < 2; i++)
      chk((i == 0) ? "dut1" : "dut3",
          {3'b0, sclk[i], sdo[i], fs[i], busy[i], ovr[i]}, exp_vec(i));
  endtask

  task automatic strobe(input logic [DW-1:0] v);
    sin = v; sv = 1'b1;
    step();
    sv = 1'b0;
  endtask

  initial begin
    int k, tg, r0, r1;
    logic prev;
    rst_n = 1'b0; en = 1'b0; sv = 1'b0; clr = 1'b0; sin = '0;
    repeat (3) step();
    chk("reset_outs", {3'b0, sclk[0], sdo[0], fs[0], busy[0], ovr[0]}, 8'd0);
    rst_n = 1'b1; en = 1'b1;
    repeat (5) step();

    // single frame of 0x5A5
    strobe(11'h5A5);
    repeat (40) step();
    chk("t1_ovr", 8'(ovr[0]), 8'd0);
    chk("t1_idle", 8'(busy[0]), 8'd0);

    // strobes at frame rate -> back-to-back frames
    for (int n = 0; n < 5; n++) begin
      strobe(DW'($urandom));
      repeat (31) step();
    end
    repeat (40) step();
    chk("t2_ovr", 8'(ovr[0]), 8'd0);
    clr = 1'b1; step(); clr = 1'b0;
    repeat (80) step();

    // overwrite of a held sample
    strobe(11'h7F0);
    repeat (6) step();
    strobe(11'h001); step();
    strobe(11'h002); step();
    strobe(11'h003);
    chk("t3_ovr_set", 8'(ovr[0]), 8'd1);
    repeat (70) step();
    chk("t3_ovr_hold", 8'(ovr[0]), 8'd1);
    clr = 1'b1; step(); clr = 1'b0;
    chk("t3_ovr_clr", 8'(ovr[0]), 8'd0);
    repeat (40) step();

    // strobe on the consume cycle, then clear racing a new overrun
    strobe(11'h111);
    repeat (4) step();
    strobe(11'h222);
    k = 0;
    while (!(m_pos[0] == FB - 1 && (m_cnt[0] + 1) % 2 == 0) && k < 200) begin
      step(); k++;
    end
    chk("t4_sync", 8'(k < 200), 8'd1);
    strobe(11'h333);
    chk("t4_no_ovr", 8'(ovr[0]), 8'd0);
    clr = 1'b1;
    strobe(11'h444);
    clr = 1'b0;
    chk("t4_set_wins", 8'(ovr[0]), 8'd1);
    repeat (80) step();
    clr = 1'b1; step(); clr = 1'b0;

    // disable mid-frame
    strobe(11'h6C3);
    k = 0;
    while (m_pos[0] != 5 && k < 200) begin step(); k++; end
    chk("t5_sync", 8'(k < 200), 8'd1);
    en = 1'b0; step();
    chk("t5_off", {4'b0, sclk[0], sdo[0], fs[0], busy[0]}, 8'd0);
    en = 1'b1;
    tg = 0; prev = sclk[0];
    repeat (40) begin
      step();
      if (sclk[0] != prev) tg++;
      prev = sclk[0];
    end
    chk("t5_sclk_tog", 8'(tg), 8'd40);
    chk("t5_idle", {6'b0, busy[0], sdo[0]}, 8'd0);

    // reset mid-frame on the CLK_DIV=3 instance, then measure sclk period
    strobe(11'h3A7);
    k = 0;
    while (m_pos[1] != 4 && k < 400) begin step(); k++; end
    chk("t6_sync", 8'(k < 400), 8'd1);
    rst_n = 1'b0; step();
    chk("t6_rst", {3'b0, sclk[1], sdo[1], fs[1], busy[1], ovr[1]}, 8'd0);
    rst_n = 1'b1;
    r0 = -1; r1 = -1; prev = sclk[1];
    for (int c = 0; c < 30; c++) begin
      step();
      if (sclk[1] && !prev) begin
        if (r0 < 0) r0 = c;
        else if (r1 < 0) r1 = c;
      end
      prev = sclk[1];
    end
    chk("t6_period", 8'(r1 - r0), 8'd6);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      sv    = ($urandom_range(0, 15) == 0);
      sin   = DW'($urandom);
      clr   = ($urandom_range(0, 40) == 0);
      rst_n = ($urandom_range(0, 1500) != 0);
      if ($urandom_range(0, 400) == 0) en = !en;
      step();
    end
    sv = 1'b0; clr = 1'b0; rst_n = 1'b1; en = 1'b1;
    repeat (10) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
